// File: rtl/coord_unshift.sv
// coord_unshift: view-relative -> world coordinates, world = view + centre - OFFSET (mod 256, or saturated).
// Latency: sample accepted at edge N is visible on M_VALID after edge N+2 (stage 1, stage 2, FIFO register).
// Backpressure: credit based; S_READY is low once FIFO_DEPTH samples are queued or in flight. Build option: UNSHIFT_CLAMP_EN.

// Small synchronous FIFO; output is always taken from a storage register, never bypassed.
module coord_unshift_fifo #(
   parameter int W     = 17,
   parameter int DEPTH = 2
) (
   input  logic                       core_clk,
   input  logic                       arst_n,
   input  logic                       wr_vld,
   input  logic [W-1:0]               wr_dat,
   output logic                       rd_vld,
   input  logic                       rd_rdy,
   output logic [W-1:0]               rd_dat,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          rd_take;

   assign rd_vld  = (count != '0);
   assign rd_take = rd_vld & rd_rdy;
   assign rd_dat  = mem[rptr];

   // Storage and pointers; entries clear on reset so the head reads as zero when idle.
   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_vld) begin
            mem[wptr] <= wr_dat;
            wptr      <= wptr + 1'b1;
         end
         if (rd_take) rptr <= rptr + 1'b1;
      end
   end

   // Occupancy count; writer is credit-limited so overflow cannot occur.
   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         count <= '0;
      end else begin
         case ({wr_vld, rd_take})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module coord_unshift #(
   parameter int OFFSET     = 128,
   parameter int FIFO_DEPTH = 2
) (
   input  logic       ACLK,
   input  logic       ARESETn,
   input  logic       S_VALID,
   output logic       S_READY,
   input  logic [7:0] S_X,
   input  logic [7:0] S_Y,
   input  logic       CENTER_WE,
   input  logic [7:0] XCENTER,
   input  logic [7:0] YCENTER,
   output logic       M_VALID,
   input  logic       M_READY,
   output logic [7:0] M_X,
   output logic [7:0] M_Y,
   output logic       M_WRAP
);
   localparam int         CW    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [9:0] OFF10 = 10'(OFFSET);
   localparam logic [7:0] OFF8  = 8'(OFFSET);

   logic [7:0]    cx, cy;
   logic          s1_vld;
   logic [7:0]    s1_x, s1_y, s1_cx, s1_cy;
   logic          s2_vld;
   logic [16:0]   s2_dat;
   logic [16:0]   res;
   logic [9:0]    dx, dy;
   logic          x_under, x_over, y_under, y_over;
   logic [7:0]    rx, ry;
   logic          accept;
   logic [CW-1:0] fcnt;
   logic [CW:0]   occ;
   logic [16:0]   head;

   assign accept  = S_VALID & S_READY;
   // Credits come only from registered state, so a same-edge output pop frees a slot one cycle later.
   assign occ     = {1'b0, fcnt} + (CW+1)'(s1_vld) + (CW+1)'(s2_vld);
   assign S_READY = (occ < (CW+1)'(FIFO_DEPTH));

   // Centre registers; a sample accepted on the same edge captures the old value.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         cx <= OFF8;
         cy <= OFF8;
      end else if (CENTER_WE) begin
         cx <= XCENTER;
         cy <= YCENTER;
      end
   end

   // Stage 1: capture coordinates together with the centre in force at acceptance.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         s1_vld <= 1'b0;
         s1_x   <= '0;
         s1_y   <= '0;
         s1_cx  <= '0;
         s1_cy  <= '0;
      end else begin
         s1_vld <= accept;
         if (accept) begin
            s1_x  <= S_X;
            s1_y  <= S_Y;
            s1_cx <= cx;
            s1_cy <= cy;
         end
      end
   end

   // Stage 2 arithmetic: 10-bit signed sums cover -255..510 without overflow.
   always_comb begin
      dx      = {2'b00, s1_x} + {2'b00, s1_cx} - OFF10;
      dy      = {2'b00, s1_y} + {2'b00, s1_cy} - OFF10;
      x_under = dx[9];
      x_over  = ~dx[9] & dx[8];
      y_under = dy[9];
      y_over  = ~dy[9] & dy[8];
`ifdef UNSHIFT_CLAMP_EN
      rx = x_under ? 8'h00 : (x_over ? 8'hFF : dx[7:0]);
      ry = y_under ? 8'h00 : (y_over ? 8'hFF : dy[7:0]);
`else
      rx = dx[7:0];
      ry = dy[7:0];
`endif
      res = {rx, ry, (x_under | x_over | y_under | y_over)};
   end

   // Stage 2 register: result heads for the output FIFO on the next edge.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         s2_vld <= 1'b0;
         s2_dat <= '0;
      end else begin
         s2_vld <= s1_vld;
         if (s1_vld) s2_dat <= res;
      end
   end

   coord_unshift_fifo #(.W(17), .DEPTH(FIFO_DEPTH)) u_fifo (
      .core_clk (ACLK),
      .arst_n   (ARESETn),
      .wr_vld   (s2_vld),
      .wr_dat   (s2_dat),
      .rd_vld   (M_VALID),
      .rd_rdy   (M_READY),
      .rd_dat   (head),
      .count    (fcnt)
   );

   assign M_X    = head[16:9];
   assign M_Y    = head[8:1];
   assign M_WRAP = head[0];
endmodule

// File: tb/tb_coord_unshift.sv
// Bench for coord_unshift: directed and random stimulus checked through a scoreboard queue.
// Timing: inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Backpressure: M_READY is held low and randomised to exercise the credit path.
module tb_coord_unshift;
   localparam int OFFSET     = 128;
   localparam int FIFO_DEPTH = 2;

   logic       ACLK = 1'b0;
   logic       ARESETn = 1'b0;
   logic       S_VALID = 1'b0;
   logic       S_READY;
   logic [7:0] S_X = '0, S_Y = '0;
   logic       CENTER_WE = 1'b0;
   logic [7:0] XCENTER = '0, YCENTER = '0;
   logic       M_VALID;
   logic       M_READY = 1'b0;
   logic [7:0] M_X, M_Y;
   logic       M_WRAP;

   int checks = 0;
   int failures = 0;
   int nin = 0;
   int n0;
   logic [7:0]  mcx = 8'd128, mcy = 8'd128;
   logic [16:0] sb[$];
   logic [16:0] dexp[$];
   logic [16:0] h;

   coord_unshift #(.OFFSET(OFFSET), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .S_VALID(S_VALID), .S_READY(S_READY), .S_X(S_X), .S_Y(S_Y),
      .CENTER_WE(CENTER_WE), .XCENTER(XCENTER), .YCENTER(YCENTER),
      .M_VALID(M_VALID), .M_READY(M_READY), .M_X(M_X), .M_Y(M_Y), .M_WRAP(M_WRAP)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [16:0] model(input logic [7:0] sx, sy, cx, cy);
      int dx, dy;
      logic [7:0] rx, ry;
      logic w;
      dx = int'(sx) + int'(cx) - OFFSET;
      dy = int'(sy) + int'(cy) - OFFSET;
      w  = (dx < 0) || (dx > 255) || (dy < 0) || (dy > 255);
`ifdef UNSHIFT_CLAMP_EN
      rx = (dx < 0) ? 8'h00 : (dx > 255) ? 8'hFF : dx[7:0];
      ry = (dy < 0) ? 8'h00 : (dy > 255) ? 8'hFF : dy[7:0];
`else
      rx = dx[7:0];
      ry = dy[7:0];
`endif
      return {rx, ry, w};
   endfunction

   // One clock: score transfers that will happen on the coming edge, then advance.
   task automatic tick();
      logic [16:0] e;
      #1;
      if (M_VALID && M_READY) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_output", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("m_x", 32'(M_X), 32'(e[16:9]));
            chk("m_y", 32'(M_Y), 32'(e[8:1]));
            chk("m_wrap", 32'(M_WRAP), 32'(e[0]));
         end
      end
      if (S_VALID && S_READY) begin
         if (dexp.size() > 0) sb.push_back(dexp.pop_front());
         else sb.push_back(model(S_X, S_Y, mcx, mcy));
         nin++;
      end
      if (CENTER_WE) begin
         mcx = XCENTER;
         mcy = YCENTER;
      end
      @(posedge ACLK);
      #1;
   endtask

   task automatic drain();
      M_READY = 1'b1;
      S_VALID = 1'b0;
      CENTER_WE = 1'b0;
      for (int i = 0; i < 100 && sb.size() > 0; i++) tick();
      chk("drain_empty", 32'(sb.size()), 32'd0);
      tick();
      chk("drain_no_dup", 32'(M_VALID), 32'd0);
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_s_ready", 32'(S_READY), 32'd1);
      chk("rst_m_valid", 32'(M_VALID), 32'd0);
      chk("rst_m_x", 32'(M_X), 32'd0);
      chk("rst_m_y", 32'(M_Y), 32'd0);
      chk("rst_m_wrap", 32'(M_WRAP), 32'd0);
      @(posedge ACLK); #1;
      ARESETn = 1'b1;
      @(posedge ACLK); #1;

      // Identity map after reset, and first-sample latency
      M_READY = 1'b1;
      S_VALID = 1'b1; S_X = 8'h40; S_Y = 8'hC0;
      dexp.push_back({8'h40, 8'hC0, 1'b0});
      tick();
      S_VALID = 1'b0;
      chk("lat_edge_n", 32'(M_VALID), 32'd0);
      tick();
      chk("lat_edge_n1", 32'(M_VALID), 32'd0);
      tick();
      chk("lat_edge_n2", 32'(M_VALID), 32'd1);
      drain();

      // Centre written on the same edge as a sample does not affect it
      CENTER_WE = 1'b1; XCENTER = 8'h30; YCENTER = 8'h90;
      S_VALID = 1'b1; S_X = 8'h10; S_Y = 8'h10;
      dexp.push_back({8'h10, 8'h10, 1'b0});
      tick();
      CENTER_WE = 1'b0;
`ifdef UNSHIFT_CLAMP_EN
      dexp.push_back({8'h00, 8'h20, 1'b1});
`else
      dexp.push_back({8'hC0, 8'h20, 1'b1});
`endif
      tick();
      drain();

      // X overflow past 255
      CENTER_WE = 1'b1; XCENTER = 8'hF0; YCENTER = 8'h80;
      tick();
      CENTER_WE = 1'b0;
      S_VALID = 1'b1; S_X = 8'hA0; S_Y = 8'h55;
`ifdef UNSHIFT_CLAMP_EN
      dexp.push_back({8'hFF, 8'h55, 1'b1});
`else
      dexp.push_back({8'h10, 8'h55, 1'b1});
`endif
      tick();
      drain();

      // Backpressure: four offered, only FIFO_DEPTH accepted, outputs hold
      M_READY = 1'b0;
      n0 = nin;
      for (int i = 0; i < 4; i++) begin
         S_VALID = 1'b1; S_X = 8'(i * 37 + 5); S_Y = 8'(200 - i * 11);
         tick();
      end
      S_VALID = 1'b0;
      chk("bp_accepted", 32'(nin - n0), 32'(FIFO_DEPTH));
      chk("bp_s_ready_low", 32'(S_READY), 32'd0);
      tick(); tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         h = sb[0];
         chk("hold_valid", 32'(M_VALID), 32'd1);
         chk("hold_x", 32'(M_X), 32'(h[16:9]));
         chk("hold_y", 32'(M_Y), 32'(h[8:1]));
         chk("hold_wrap", 32'(M_WRAP), 32'(h[0]));
      end
      M_READY = 1'b1;
      chk("credit_not_comb", 32'(S_READY), 32'd0);
      tick();
      chk("credit_next_cycle", 32'(S_READY), 32'd1);
      drain();

      // Random valid/ready with occasional centre updates
      n0 = nin;
      for (int c = 0; c < 30000 && (nin - n0) < 1000; c++) begin
         S_VALID   = 1'($urandom_range(0, 1));
         M_READY   = ($urandom_range(0, 3) != 0);
         CENTER_WE = ($urandom_range(0, 15) == 0);
         XCENTER   = 8'($urandom);
         YCENTER   = 8'($urandom);
         S_X       = 8'($urandom);
         S_Y       = 8'($urandom);
         tick();
      end
      chk("rand_count", 32'(nin - n0), 32'd1000);
      drain();

      // Asynchronous reset with samples queued
      CENTER_WE = 1'b1; XCENTER = 8'h20; YCENTER = 8'h20;
      tick();
      CENTER_WE = 1'b0;
      M_READY = 1'b0;
      S_VALID = 1'b1; S_X = 8'h11; S_Y = 8'h22;
      tick(); tick();
      S_VALID = 1'b0;
      tick(); tick(); tick();
      chk("pre_rst_valid", 32'(M_VALID), 32'd1);
      #2;
      ARESETn = 1'b0;
      #1;
      chk("arst_m_valid", 32'(M_VALID), 32'd0);
      chk("arst_s_ready", 32'(S_READY), 32'd1);
      chk("arst_m_x", 32'(M_X), 32'd0);
      sb.delete();
      mcx = 8'd128; mcy = 8'd128;
      @(posedge ACLK); #1;
      ARESETn = 1'b1;
      M_READY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("no_stale", 32'(M_VALID), 32'd0);
      end
      S_VALID = 1'b1; S_X = 8'h40; S_Y = 8'h40;
      dexp.push_back({8'h40, 8'h40, 1'b0});
      tick();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
